// File: rtl/bank_pkg.sv
// Shared types and widths for the multi-bank deposit controller and its key sampler.
package bank_pkg;

  localparam int unsigned TOTAL_W    = 16;
  localparam int unsigned BANK_IDX_W = 3;
  localparam int unsigned X_W        = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/key_tick_edge.sv
// Game-tick key sampler: reports a fresh press and the held level for the tick being taken.
// Reusable for any active-low push button (KEY[0..2]).
module key_tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic tick_en,
  input  logic key_n,
  output logic press_edge_c,
  output logic held_c
);

  logic pressed;
  logic q1;
  logic armed;

  assign pressed = ~key_n;

  // armed stays low until a released sample is seen, so a key held through reset never fires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1    <= 1'b0;
      armed <= 1'b0;
    end else if (tick_en) begin
      q1    <= pressed;
      armed <= armed | ~pressed;
    end
  end

  // Look-ahead of the sampled edge so the attempt lands on the same tick the press is taken
  assign press_edge_c = pressed & ~q1 & armed;
  assign held_c       = pressed;

endmodule

// File: rtl/multi_bank_control.sv
// Multi-bank deposit controller: X-zone bank match, saturating per-bank levels and a
// press/hold/cooldown drop FSM. Define MULTI_BANK_AUTOREPEAT_EN to repeat drops while held.
module multi_bank_control
  import bank_pkg::*;
#(
  parameter int unsigned              NUM_BANKS          = 2,
  parameter logic [X_W-1:0]           PLAYER_BASE_HEIGHT = 10'd30,
  parameter logic [NUM_BANKS*X_W-1:0] BANK_X_STARTS      = {10'd400, 10'd50},
  parameter logic [X_W-1:0]           BANK_WIDTH         = 10'd60,
  parameter int unsigned              LEVEL_W            = 8,
  parameter int unsigned              BANK_CAPACITY      = 255,
  parameter int unsigned              REPEAT_TICKS       = 8,
  parameter int unsigned              COOLDOWN_TICKS     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         game_en,
  input  logic                         key_2_in,
  input  logic [X_W-1:0]               player_x_pos,
  input  logic [X_W-1:0]               player_current_height,
  output logic                         box_dropped,
  output logic                         drop_rejected,
  output logic [BANK_IDX_W-1:0]        bank_hit_idx,
  output logic [NUM_BANKS*LEVEL_W-1:0] bank_levels,
  output logic [NUM_BANKS-1:0]         bank_full,
  output logic [TOTAL_W-1:0]           total_banked
);

  localparam int unsigned CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
`ifdef MULTI_BANK_AUTOREPEAT_EN
  localparam int unsigned REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
`endif

  if (NUM_BANKS < 1 || NUM_BANKS > 8 || REPEAT_TICKS < 1 || BANK_CAPACITY < 1 ||
      64'(BANK_CAPACITY) >= (64'd1 << LEVEL_W)) begin : g_bad_params
    $error("multi_bank_control: parameter out of range");
  end

  logic press_edge_c;
  logic held_c;

  key_tick_edge u_key (
    .clk          (clk),
    .rst          (rst),
    .tick_en      (game_en),
    .key_n        (key_2_in),
    .press_edge_c (press_edge_c),
    .held_c       (held_c)
  );

  // Bank match in 11 bits so start+width never wraps; lowest index wins on overlap
  logic [X_W:0]            x_ext;
  logic                    hit_c;
  logic                    hit_full_c;
  logic                    accept_c;
  logic [BANK_IDX_W-1:0]   hit_idx_c;

  assign x_ext = {1'b0, player_x_pos};

  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    hit_full_c = 1'b0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (x_ext >= {1'b0, BANK_X_STARTS[X_W*i +: X_W]} &&
          x_ext <  {1'b0, BANK_X_STARTS[X_W*i +: X_W]} + {1'b0, BANK_WIDTH}) begin
        hit_c      = 1'b1;
        hit_idx_c  = BANK_IDX_W'(i);
        hit_full_c = bank_full[i];
      end
    end
  end

  assign accept_c = hit_c & (player_current_height > PLAYER_BASE_HEIGHT) & ~hit_full_c;

  state_t            state_q, state_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic              attempt_c;
`ifdef MULTI_BANK_AUTOREPEAT_EN
  logic [REP_W-1:0]  rep_q, rep_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
`ifdef MULTI_BANK_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else if (game_en) begin
      state_q <= state_d;
      cd_q    <= cd_d;
`ifdef MULTI_BANK_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    attempt_c = 1'b0;
`ifdef MULTI_BANK_AUTOREPEAT_EN
    rep_d     = rep_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (press_edge_c) begin
          attempt_c = 1'b1;
          state_d   = ST_HOLD;
`ifdef MULTI_BANK_AUTOREPEAT_EN
          rep_d     = '0;
`endif
        end
      end
      ST_HOLD: begin
        if (!held_c) begin
          if (COOLDOWN_TICKS == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COOLDOWN;
            cd_d    = CD_W'(COOLDOWN_TICKS - 1);
          end
        end
`ifdef MULTI_BANK_AUTOREPEAT_EN
        else if (rep_q == REP_W'(REPEAT_TICKS - 1)) begin
          attempt_c = 1'b1;
          rep_d     = '0;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
`endif
      end
      ST_COOLDOWN: begin
        if (cd_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cd_d = cd_q - CD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulses, levels, full flags and the running total all advance on game ticks only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_dropped   <= 1'b0;
      drop_rejected <= 1'b0;
      bank_hit_idx  <= '0;
      bank_levels   <= '0;
      bank_full     <= '0;
      total_banked  <= '0;
    end else if (game_en) begin
      box_dropped   <= attempt_c & accept_c;
      drop_rejected <= attempt_c & ~accept_c;
      if (attempt_c && accept_c) begin
        bank_hit_idx <= hit_idx_c;
        if (total_banked != '1) begin
          total_banked <= total_banked + TOTAL_W'(1);
        end
        for (int i = 0; i < NUM_BANKS; i++) begin
          if (hit_idx_c == BANK_IDX_W'(i)) begin
            bank_levels[LEVEL_W*i +: LEVEL_W] <= bank_levels[LEVEL_W*i +: LEVEL_W] + LEVEL_W'(1);
            bank_full[i] <= (bank_levels[LEVEL_W*i +: LEVEL_W] == LEVEL_W'(BANK_CAPACITY - 1));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_bank_control.sv
// Self-checking bench for multi_bank_control: directed scenarios plus randomized ticks
// compared against a tick-count based behavioural model.
module tb_multi_bank_control;

  localparam int NB   = 2;
  localparam int BASE = 30;
  localparam int BW   = 60;
  localparam int LW   = 8;
  localparam int CAP  = 255;
  localparam int RT   = 8;
  localparam int CT   = 4;
  localparam logic [NB*10-1:0] STARTS = {10'd400, 10'd50};
`ifdef MULTI_BANK_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              game_en;
  logic              key_2_in;
  logic [9:0]        player_x_pos;
  logic [9:0]        player_current_height;
  logic              box_dropped;
  logic              drop_rejected;
  logic [2:0]        bank_hit_idx;
  logic [NB*LW-1:0]  bank_levels;
  logic [NB-1:0]     bank_full;
  logic [15:0]       total_banked;

  int checks = 0;
  int errors = 0;

  multi_bank_control #(
    .NUM_BANKS          (NB),
    .PLAYER_BASE_HEIGHT (10'd30),
    .BANK_X_STARTS      (STARTS),
    .BANK_WIDTH         (10'd60),
    .LEVEL_W            (LW),
    .BANK_CAPACITY      (CAP),
    .REPEAT_TICKS       (RT),
    .COOLDOWN_TICKS     (CT)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .game_en               (game_en),
    .key_2_in              (key_2_in),
    .player_x_pos          (player_x_pos),
    .player_current_height (player_current_height),
    .box_dropped           (box_dropped),
    .drop_rejected         (drop_rejected),
    .bank_hit_idx          (bank_hit_idx),
    .bank_levels           (bank_levels),
    .bank_full             (bank_full),
    .total_banked          (total_banked)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Behavioural model: press/release tick arithmetic instead of counters
  int m_lvl [NB];
  int m_total, m_idx, m_t, m_press_t, m_idle_from;
  bit m_drop, m_rej, m_in_hold, m_armed, m_prev_k;

  function automatic int bank_start(input int i);
    logic [NB*10-1:0] s;
    s = STARTS;
    return int'(s[10*i +: 10]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_lvl[i] = 0;
    m_total = 0; m_idx = 0; m_t = 0; m_press_t = 0; m_idle_from = 0;
    m_drop = 0; m_rej = 0; m_in_hold = 0; m_armed = 0; m_prev_k = 0;
  endtask

  task automatic model_step(input bit k, input int x, input int h);
    bit att;
    int b;
    att = 0;
    m_drop = 0;
    m_rej = 0;
    if (m_in_hold) begin
      if (!k) begin
        m_in_hold = 0;
        m_idle_from = m_t + CT + 1;
      end else if (AUTO && ((m_t - m_press_t) % RT == 0)) begin
        att = 1;
      end
    end else if (m_t >= m_idle_from && k && !m_prev_k && m_armed) begin
      att = 1;
      m_in_hold = 1;
      m_press_t = m_t;
    end
    if (att) begin
      b = -1;
      for (int i = NB - 1; i >= 0; i--)
        if (x >= bank_start(i) && x < bank_start(i) + BW) b = i;
      if (b >= 0 && h > BASE && m_lvl[b] < CAP) begin
        m_drop = 1;
        m_lvl[b]++;
        m_idx = b;
        if (m_total < 65535) m_total++;
      end else begin
        m_rej = 1;
      end
    end
    if (!k) m_armed = 1;
    m_prev_k = k;
    m_t++;
  endtask

  // One game tick, then 0..2 frozen cycles with junk inputs
  task automatic do_tick(input bit press, input logic [9:0] x, input logic [9:0] h);
    int idle;
    @(negedge clk);
    key_2_in = ~press;
    player_x_pos = x;
    player_current_height = h;
    game_en = 1'b1;
    model_step(press, int'(x), int'(h));
    @(posedge clk);
    #1;
    game_en = 1'b0;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      key_2_in = 1'($urandom);
      player_x_pos = 10'($urandom);
    end
  endtask

  task automatic release_wait(input logic [9:0] x, input logic [9:0] h);
    for (int i = 0; i < CT + 1; i++) do_tick(1'b0, x, h);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    game_en = 1'b0;
    key_2_in = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_tick(1'b0, 10'd200, 10'd30);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    game_en = 1'b0;
    key_2_in = 1'b1;
    player_x_pos = 10'd0;
    player_current_height = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (box_dropped !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", box_dropped); end
    checks++; if (drop_rejected !== 1'b0) begin errors++; $display("FAIL reset_rej got %b exp 0", drop_rejected); end
    checks++; if (bank_hit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", bank_hit_idx); end
    checks++; if (bank_levels !== '0) begin errors++; $display("FAIL reset_levels got %h exp 0", bank_levels); end
    checks++; if (bank_full !== '0) begin errors++; $display("FAIL reset_full got %b exp 0", bank_full); end
    checks++; if (total_banked !== 16'd0) begin errors++; $display("FAIL reset_total got %0d exp 0", total_banked); end
    rst = 1'b1;
    do_tick(1'b0, 10'd200, 10'd30);
  endtask

  task automatic test_single_drop();
    do_tick(1'b1, 10'd70, 10'd40);
    checks++; if (box_dropped !== 1'b1) begin errors++; $display("FAIL single_drop got %b exp 1", box_dropped); end
    checks++; if (drop_rejected !== 1'b0) begin errors++; $display("FAIL single_rej got %b exp 0", drop_rejected); end
    checks++; if (bank_levels !== 16'h0001) begin errors++; $display("FAIL single_levels got %h exp 0001", bank_levels); end
    checks++; if (bank_hit_idx !== 3'd0) begin errors++; $display("FAIL single_idx got %0d exp 0", bank_hit_idx); end
    checks++; if (total_banked !== 16'd1) begin errors++; $display("FAIL single_total got %0d exp 1", total_banked); end
    do_tick(1'b1, 10'd70, 10'd40);
    checks++; if (box_dropped !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b exp 0", box_dropped); end
    release_wait(10'd70, 10'd40);
  endtask

  task automatic test_no_bank();
    do_tick(1'b1, 10'd200, 10'd40);
    checks++; if (drop_rejected !== 1'b1) begin errors++; $display("FAIL nobank_rej got %b exp 1", drop_rejected); end
    checks++; if (box_dropped !== 1'b0) begin errors++; $display("FAIL nobank_drop got %b exp 0", box_dropped); end
    checks++; if (bank_levels !== 16'h0001) begin errors++; $display("FAIL nobank_levels got %h exp 0001", bank_levels); end
    release_wait(10'd200, 10'd40);
    checks++; if (drop_rejected !== 1'b0) begin errors++; $display("FAIL nobank_rej_clear got %b exp 0", drop_rejected); end
  endtask

  task automatic test_height_cooldown();
    do_tick(1'b1, 10'd420, 10'd30);
    checks++; if (drop_rejected !== 1'b1) begin errors++; $display("FAIL height_rej got %b exp 1", drop_rejected); end
    checks++; if (bank_levels !== 16'h0001) begin errors++; $display("FAIL height_levels got %h exp 0001", bank_levels); end
    release_wait(10'd420, 10'd40);
    do_tick(1'b1, 10'd420, 10'd40);
    checks++; if (box_dropped !== 1'b1) begin errors++; $display("FAIL bank1_drop got %b exp 1", box_dropped); end
    checks++; if (bank_hit_idx !== 3'd1) begin errors++; $display("FAIL bank1_idx got %0d exp 1", bank_hit_idx); end
    checks++; if (bank_levels !== 16'h0101) begin errors++; $display("FAIL bank1_levels got %h exp 0101", bank_levels); end
    checks++; if (total_banked !== 16'd2) begin errors++; $display("FAIL bank1_total got %0d exp 2", total_banked); end
    release_wait(10'd420, 10'd40);
  endtask

  task automatic test_hold_repeat();
    bit exp;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      do_tick(1'b1, 10'd60, 10'd45);
      exp = (i % RT == 0) && (AUTO || i == 0);
      checks++;
      if (box_dropped !== exp) begin
        errors++; $display("FAIL hold_tick%0d_drop got %b exp %b", i, box_dropped, exp);
      end
    end
    release_wait(10'd60, 10'd45);
    checks++;
    if (bank_levels[7:0] !== (AUTO ? 8'd5 : 8'd1)) begin
      errors++; $display("FAIL hold_level got %0d exp %0d", bank_levels[7:0], AUTO ? 5 : 1);
    end
  endtask

  task automatic test_bank_full();
    do_reset();
    for (int n = 0; n < CAP; n++) begin
      do_tick(1'b1, 10'd70, 10'd40);
      if (n == CAP - 2) begin
        checks++; if (bank_full[0] !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", bank_full[0]); end
      end
      if (n == CAP - 1) begin
        checks++; if (bank_levels[7:0] !== 8'd255) begin errors++; $display("FAIL full_level got %0d exp 255", bank_levels[7:0]); end
        checks++; if (bank_full[0] !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", bank_full[0]); end
      end
      release_wait(10'd70, 10'd40);
    end
    do_tick(1'b1, 10'd70, 10'd40);
    checks++; if (drop_rejected !== 1'b1) begin errors++; $display("FAIL full_rej got %b exp 1", drop_rejected); end
    checks++; if (box_dropped !== 1'b0) begin errors++; $display("FAIL full_drop got %b exp 0", box_dropped); end
    checks++; if (total_banked !== 16'd255) begin errors++; $display("FAIL full_total got %0d exp 255", total_banked); end
    do_tick(1'b0, 10'd420, 10'd40);
    do_tick(1'b0, 10'd420, 10'd40);
    for (int i = 0; i < 4; i++) begin
      do_tick(1'b1, 10'd420, 10'd40);
      checks++; if (box_dropped !== 1'b0) begin errors++; $display("FAIL cooldown_press%0d got %b exp 0", i, box_dropped); end
    end
    checks++; if (bank_levels[15:8] !== 8'd0) begin errors++; $display("FAIL cooldown_level got %0d exp 0", bank_levels[15:8]); end
    release_wait(10'd420, 10'd40);
    do_tick(1'b1, 10'd420, 10'd40);
    checks++; if (box_dropped !== 1'b1) begin errors++; $display("FAIL after_cooldown_drop got %b exp 1", box_dropped); end
    checks++; if (bank_hit_idx !== 3'd1) begin errors++; $display("FAIL after_cooldown_idx got %0d exp 1", bank_hit_idx); end
    release_wait(10'd420, 10'd40);
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    for (int n = 0; n < 2; n++) begin
      do_tick(1'b1, 10'd70, 10'd40);
      release_wait(10'd70, 10'd40);
    end
    do_tick(1'b1, 10'd70, 10'd40);
    do_tick(1'b1, 10'd70, 10'd40);
    checks++; if (bank_levels[7:0] !== 8'd3) begin errors++; $display("FAIL midhold_level got %0d exp 3", bank_levels[7:0]); end
    @(negedge clk);
    key_2_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (bank_levels !== '0) begin errors++; $display("FAIL midhold_rst_levels got %h exp 0", bank_levels); end
    checks++; if (total_banked !== 16'd0) begin errors++; $display("FAIL midhold_rst_total got %0d exp 0", total_banked); end
    checks++; if (bank_full !== '0 || bank_hit_idx !== 3'd0) begin errors++; $display("FAIL midhold_rst_flags got %b/%0d exp 0/0", bank_full, bank_hit_idx); end
    checks++; if (box_dropped !== 1'b0 || drop_rejected !== 1'b0) begin errors++; $display("FAIL midhold_rst_pulses got %b%b exp 00", box_dropped, drop_rejected); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      do_tick(1'b1, 10'd70, 10'd40);
      checks++;
      if (box_dropped !== 1'b0 || bank_levels !== '0) begin
        errors++; $display("FAIL held_through_reset tick%0d got drop %b levels %h exp 0 0", i, box_dropped, bank_levels);
      end
    end
    release_wait(10'd70, 10'd40);
    do_tick(1'b1, 10'd70, 10'd40);
    checks++; if (box_dropped !== 1'b1) begin errors++; $display("FAIL repress_drop got %b exp 1", box_dropped); end
    checks++; if (bank_levels[7:0] !== 8'd1) begin errors++; $display("FAIL repress_level got %0d exp 1", bank_levels[7:0]); end
    release_wait(10'd70, 10'd40);
  endtask

  task automatic test_random();
    int xs [11] = '{45, 50, 60, 109, 110, 200, 399, 400, 459, 460, 1023};
    int hs [4]  = '{29, 30, 31, 40};
    bit press;
    logic [NB*LW-1:0] e_lvl;
    logic [NB-1:0]    e_full;
    press = 1'b0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) press = ~press;
      do_tick(press, 10'(xs[$urandom_range(0, 10)]), 10'(hs[$urandom_range(0, 3)]));
      for (int i = 0; i < NB; i++) begin
        e_lvl[LW*i +: LW] = LW'(m_lvl[i]);
        e_full[i] = (m_lvl[i] == CAP);
      end
      checks++;
      if (box_dropped !== m_drop || drop_rejected !== m_rej) begin
        errors++; $display("FAIL rand%0d_pulses got %b%b exp %b%b", n, box_dropped, drop_rejected, m_drop, m_rej);
      end
      checks++;
      if (bank_levels !== e_lvl || bank_full !== e_full) begin
        errors++; $display("FAIL rand%0d_levels got %h/%b exp %h/%b", n, bank_levels, bank_full, e_lvl, e_full);
      end
      checks++;
      if (bank_hit_idx !== 3'(m_idx) || total_banked !== 16'(m_total)) begin
        errors++; $display("FAIL rand%0d_idx_total got %0d/%0d exp %0d/%0d", n, bank_hit_idx, total_banked, m_idx, m_total);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_drop();
    test_no_bank();
    test_height_cooldown();
    test_hold_repeat();
    test_bank_full();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
